// File: rtl/gps_uart_pkg.sv
// Shared definitions for the GPS / telemetry UART sharing logic.
//   - arb_state_e   : frame arbiter state encoding (2 bits)
//   - N_REQ_DEFAULT : default number of byte-stream requesters
//   - UBX_SYNC1/2   : UBX frame sync bytes, handy for requester benches
package gps_uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_HOLD = 2'd2,
    S_WAIT = 2'd3
  } arb_state_e;

  localparam int N_REQ_DEFAULT = 2;

  localparam logic [7:0] UBX_SYNC1 = 8'hB5;
  localparam logic [7:0] UBX_SYNC2 = 8'h62;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Scans req_i starting one position after last_grant_i, wrapping at N,
// and returns the first set index. Reusable by any shared-resource scheduler.
// Ports:
//   req_i        : request vector, one bit per requester
//   last_grant_i : index served most recently (scan starts just after it)
//   pick_o       : index of the winning requester (0 when none)
//   any_o        : at least one request is set
module rr_picker #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_grant_i,
  output logic [W-1:0] pick_o,
  output logic         any_o
);

  logic [W-1:0] idx;

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    pick_o = '0;
    any_o  = 1'b0;
    idx    = '0;
    // Offset N revisits last_grant itself, so a lone repeat requester still wins.
    for (int off = 1; off <= N; off++) begin
      idx = W'((int'(last_grant_i) + off) % N);
      if (!any_o && req_i[idx]) begin
        pick_o = idx;
        any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level arbiter sharing one UART transmitter between N_REQ byte streams.
// A granted requester keeps the transmitter until it sends a byte flagged
// last, so frames never interleave. Owners are chosen round-robin, and a
// watchdog revokes the lock if the owner leaves req_valid low for
// GAP_TIMEOUT cycles mid-frame.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   req_valid  : per-requester byte present
//   req_data   : flattened bytes, requester i on [8i+7:8i]
//   req_last   : per-requester "this byte ends the frame"
//   req_ack    : one-cycle pulse, byte consumed
//   tx_data    : registered byte to the UART
//   tx_send    : one-cycle send strobe to the UART
//   tx_busy    : UART busy
//   grant      : current or most recent owner
//   active     : a frame lock is held
//   timeout    : one-cycle pulse when the watchdog releases the lock
module uart_tx_arbiter
  import gps_uart_pkg::*;
#(
  parameter  int N_REQ       = N_REQ_DEFAULT,
  parameter  int GAP_TIMEOUT = 1000,
  localparam int GW          = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ack,
  output logic [7:0]         tx_data,
  output logic               tx_send,
  input  logic               tx_busy,
  output logic [GW-1:0]      grant,
  output logic               active,
  output logic               timeout
);

  localparam int            CW      = $clog2(GAP_TIMEOUT + 1);
  localparam logic [CW-1:0] GAP_MAX = CW'(GAP_TIMEOUT);

  arb_state_e       state_q;
  logic [GW-1:0]    grant_q, last_grant_q;
  logic [CW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             last_q, active_q, timeout_q, tx_send_q;
  logic [7:0]       tx_data_q;
  logic [N_REQ-1:0] req_ack_q;

  logic [GW-1:0]    pick;
  logic             any_req;
  logic             owner_valid, owner_last;
  logic [7:0]       owner_byte;

  rr_picker #(
    .N (N_REQ),
    .W (GW)
  ) u_picker (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .pick_o       (pick),
    .any_o        (any_req)
  );

  always_comb begin
    owner_valid = req_valid[grant_q];
    owner_last  = req_last[grant_q];
    owner_byte  = req_data[{grant_q, 3'b000} +: 8];
    // Saturating increment: the counter can never wrap back to zero.
    gap_cnt_d   = (gap_cnt_q == GAP_MAX) ? gap_cnt_q : gap_cnt_q + CW'(1);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      gap_cnt_q    <= '0;
      last_q       <= 1'b0;
      active_q     <= 1'b0;
      timeout_q    <= 1'b0;
      tx_send_q    <= 1'b0;
      tx_data_q    <= '0;
      req_ack_q    <= '0;
    end else begin
      // Pulse outputs default low; only the accepting/timeout cycle raises them.
      tx_send_q <= 1'b0;
      req_ack_q <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            grant_q   <= pick;
            active_q  <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          if (owner_valid) begin
            // Valid but UART busy: wait with the gap counter frozen.
            if (!tx_busy) begin
              tx_data_q <= owner_byte;
              tx_send_q <= 1'b1;
              req_ack_q <= N_REQ'(1) << grant_q;
              last_q    <= owner_last;
              gap_cnt_q <= '0;
              state_q   <= S_HOLD;
            end
          end else begin
            gap_cnt_q <= gap_cnt_d;
            if (gap_cnt_d == GAP_MAX) begin
              timeout_q    <= 1'b1;
              active_q     <= 1'b0;
              last_grant_q <= grant_q;
              state_q      <= S_IDLE;
            end
          end
        end
        // Guard cycle giving the UART time to raise tx_busy after the strobe.
        S_HOLD: state_q <= S_WAIT;
        S_WAIT: begin
          if (!tx_busy) begin
            if (last_q) begin
              active_q     <= 1'b0;
              last_grant_q <= grant_q;
              state_q      <= S_IDLE;
            end else begin
              state_q <= S_SEND;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ack = req_ack_q;
  assign tx_data = tx_data_q;
  assign tx_send = tx_send_q;
  assign grant   = grant_q;
  assign active  = active_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (3 requesters, 20-cycle gap watchdog).
// Requester queues feed bytes; every pushed byte also goes to an expected
// queue in the order the arbiter should send it. A behavioural UART stays
// busy BUSY cycles after each strobe.
module tb_uart_tx_arbiter;
  import gps_uart_pkg::*;

  localparam int N    = 3;
  localparam int GAP  = 20;
  localparam int BUSY = 10;

  typedef struct {
    int         r;
    logic [7:0] d;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_ack;
  logic [7:0]     tx_data;
  logic           tx_send;
  logic           tx_busy;
  logic [1:0]     grant;
  logic           active;
  logic           timeout;

  logic model_busy = 1'b0;
  logic hold_busy  = 1'b0;
  assign tx_busy = model_busy | hold_busy;

  exp_t       exp_q[$];
  logic [8:0] rq[N][$];

  int n_checks = 0, n_errors = 0;
  int cyc = 0, sends = 0, acks = 0, timeouts = 0;
  int busy_cnt = 0, busy_fall_cyc = 0;

  uart_tx_arbiter #(
    .N_REQ       (N),
    .GAP_TIMEOUT (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ack   (req_ack),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .tx_busy   (tx_busy),
    .grant     (grant),
    .active    (active),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic last);
    exp_t e;
    rq[r].push_back({last, d});
    e.r = r;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (t < 3000 && !(exp_q.size() == 0 && active == 1'b0 && busy_cnt == 0)) begin
      @(posedge clk); #1;
      t++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_active"}, active, 0);
  endtask

  task automatic wait_sends(input int target);
    int t = 0;
    while (t < 3000 && sends < target) begin
      @(posedge clk); #1;
      t++;
    end
    check("wait_sends", sends >= target, 1);
  endtask

  // Monitor, UART model and requester drivers, all on the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    cyc++;
    if (rst) begin
      if (tx_send) begin
        sends++;
        check("send_busy_low", tx_busy, 0);
        check("send_active", active, 1);
        check("send_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tx_data", tx_data, e.d);
          check("grant", grant, e.r);
          check("req_ack", req_ack, 32'(1) << e.r);
        end
      end
      acks += $countones(req_ack);
      if (timeout) begin
        timeouts++;
        check("timeout_delay", cyc - busy_fall_cyc, GAP + 1);
        check("timeout_active", active, 0);
      end
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) begin
          check("ack_has_byte", rq[i].size() != 0, 1);
          if (rq[i].size() != 0) void'(rq[i].pop_front());
        end
      end
    end
    if (tx_send) begin
      model_busy = 1'b1;
      busy_cnt   = BUSY;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        model_busy    = 1'b0;
        busy_fall_cyc = cyc;
      end
    end
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (rq[i].size() != 0);
      {req_last[i], req_data[8*i +: 8]} = (rq[i].size() != 0) ? rq[i][0] : 9'h0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int s, a;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_send", tx_send, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_req_ack", req_ack, 0);
    check("rst_grant", grant, 0);
    check("rst_active", active, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b1;

    // Contention from reset: req0 frame fully first, then req1.
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1);
    push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b0); push(1, 8'h22, 1'b1);
    wait_idle("contention");
    check("contention_timeouts", timeouts, 0);

    // Single requester UBX header; req0 wins again after req1.
    push(0, UBX_SYNC1, 1'b0); push(0, UBX_SYNC2, 1'b0);
    push(0, 8'h06, 1'b0);     push(0, 8'h01, 1'b1);
    wait_idle("ubx");
    check("ubx_sends", sends, 10);

    // Stall: req1 stops after 2 bytes; watchdog hands over to req0.
    push(1, 8'hC1, 1'b0); push(1, 8'hC2, 1'b0);
    push(0, 8'hD1, 1'b0); push(0, 8'hD2, 1'b1);
    wait_idle("stall");
    check("stall_timeouts", timeouts, 1);
    check("stall_sends", sends, 14);

    // Back-pressure: UART busy for 100 cycles with a byte waiting.
    hold_busy = 1'b1;
    push(2, 8'h77, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_active", active, 1);
    check("bp_grant", grant, 2);
    s = sends;
    a = acks;
    repeat (100) @(posedge clk);
    #1;
    check("bp_no_send", sends, s);
    check("bp_no_ack", acks, a);
    check("bp_no_timeout", timeouts, 1);
    hold_busy = 1'b0;
    wait_idle("bp");
    check("bp_one_send", sends, s + 1);
    check("bp_acks", acks, a + 1);

    // Single-byte frames from all three requesters: grants rotate 0,1,2,0,1,2.
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < N; r++)
        push(r, 8'(8'h80 + 16 * k + r), 1'b1);
    wait_idle("rr");
    check("rr_sends", sends, 21);

    // Reset mid-frame: last owner is req0, then req1 is cut off in byte 3.
    push(0, 8'hA0, 1'b1);
    wait_idle("pre_reset");
    push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b0);
    push(1, 8'h13, 1'b0); push(1, 8'h14, 1'b1);
    wait_sends(25);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_tx_send", tx_send, 0);
    check("mid_rst_active", active, 0);
    check("mid_rst_req_ack", req_ack, 0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_tx_data", tx_data, 0);
    rq[1].delete();
    exp_q.delete();
    push(0, 8'h31, 1'b1);
    push(1, 8'h21, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    wait_idle("post_reset");
    check("final_sends", sends, 27);
    check("final_timeouts", timeouts, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
